// File: rtl/ghostchip_pkg.sv
// Shared display constants and pixel/colour types for the VRAM writer and scanout.
package ghostchip_pkg;

  localparam int unsigned DISPLAY_W = 128;
  localparam int unsigned DISPLAY_H = 64;
  localparam int unsigned PIXEL_W   = 2;
  localparam int unsigned HPOS_W    = $clog2(DISPLAY_W);
  localparam int unsigned VPOS_W    = $clog2(DISPLAY_H);
  localparam int unsigned RGB_W     = 12;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  // Replicate the 2-bit pixel into each 4-bit channel (0->0x000 ... 3->0xFFF).
  function automatic rgb_t gray_rgb(input pixel_t p);
    return {3{p, p}};
  endfunction

endpackage

// File: rtl/vram_scanout_if.sv
// VRAM read port: address from the scanout, pixel data returned one clk later.
interface vram_scanout_if;
  import ghostchip_pkg::*;

  logic [HPOS_W-1:0] vram_hpos;
  logic [VPOS_W-1:0] vram_vpos;
  pixel_t            vram_pixelo;

  modport master (output vram_hpos, output vram_vpos, input vram_pixelo);
  modport slave  (input vram_hpos, input vram_vpos, output vram_pixelo);

endinterface

// File: rtl/vram_scanout_timing.sv
// VGA raster counters with the visible flag and raw active-low syncs decoded from them.
module vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned HCNT_W   = 10,
  parameter int unsigned VCNT_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  output logic [HCNT_W-1:0] hcnt_o,
  output logic [VCNT_W-1:0] vcnt_o,
  output logic              visible_c_o,
  output logic              hsync_c_o,
  output logic              vsync_c_o
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q + HCNT_W'(1);
    vcnt_d = vcnt_q;
    if (32'(hcnt_q) == H_TOTAL - 1) begin
      hcnt_d = '0;
      vcnt_d = (32'(vcnt_q) == V_TOTAL - 1) ? '0 : vcnt_q + VCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Region decodes compare in 32 bits so an end bound equal to 2**W cannot wrap.
  assign visible_c_o = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
  assign hsync_c_o   = !((32'(hcnt_q) >= HS_START) && (32'(hcnt_q) < HS_END));
  assign vsync_c_o   = !((32'(vcnt_q) >= VS_START) && (32'(vcnt_q) < VS_END));
  assign hcnt_o      = hcnt_q;
  assign vcnt_o      = vcnt_q;

endmodule

// File: rtl/vram_scanout.sv
// VRAM display reader: raster timing, window-to-VRAM mapping and registered video out.
// Optional palette registers (pal_we/pal_idx/pal_data) when SCANOUT_PALETTE_EN is defined.
module vram_scanout
  import ghostchip_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned X_OFFSET    = 64,
  parameter int unsigned Y_OFFSET    = 112
) (
  input  logic           clk,
  input  logic           reset,
  vram_scanout_if.master vram,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output rgb_t           rgb,
  output logic           frame_start
`ifdef SCANOUT_PALETTE_EN
  ,
  input  logic           pal_we,
  input  logic [1:0]     pal_idx,
  input  rgb_t           pal_data
`endif
);

  localparam int unsigned HCNT_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned VCNT_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int unsigned WIN_W  = DISPLAY_W << SCALE_SHIFT;
  localparam int unsigned WIN_H  = DISPLAY_H << SCALE_SHIFT;

  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  logic              visible_c, hsync_raw_c, vsync_raw_c;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HCNT_W(HCNT_W), .VCNT_W(VCNT_W)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .hcnt_o      (hcnt),
    .vcnt_o      (vcnt),
    .visible_c_o (visible_c),
    .hsync_c_o   (hsync_raw_c),
    .vsync_c_o   (vsync_raw_c)
  );

  // Stage 0: window mapping in signed int so positions left/above the window go negative.
  int   hd_c, vd_c;
  logic in_win_c, first_c;

  always_comb begin
    hd_c     = int'(hcnt) - int'(X_OFFSET);
    vd_c     = int'(vcnt) - int'(Y_OFFSET);
    in_win_c = visible_c && (hd_c >= 0) && (hd_c < int'(WIN_W))
                         && (vd_c >= 0) && (vd_c < int'(WIN_H));
    first_c  = (hcnt == '0) && (vcnt == '0);
    vram.vram_hpos = in_win_c ? HPOS_W'(hd_c >>> SCALE_SHIFT) : '0;
    vram.vram_vpos = in_win_c ? VPOS_W'(vd_c >>> SCALE_SHIFT) : '0;
  end

  logic s1_de_q, s1_hs_q, s1_vs_q, s1_fs_q, s1_win_q;
  logic de_q, hs_q, vs_q, fs_q;
  rgb_t rgb_q, colour_c;
  pixel_t pix_c;

  assign pix_c = s1_win_q ? vram.vram_pixelo : '0;

`ifdef SCANOUT_PALETTE_EN
  rgb_t pal_q [4];

  // Reads see the pre-write entry, so a same-clk write shows up one pixel later.
  always_ff @(posedge clk) begin
    if (reset) begin
      pal_q <= '{12'h000, 12'h555, 12'hAAA, 12'hFFF};
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_data;
    end
  end

  assign colour_c = pal_q[pix_c];
`else
  assign colour_c = gray_rgb(pix_c);
`endif

  // Stage 1 carries controls alongside the VRAM read; stage 2 is the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_de_q  <= 1'b0;
      s1_hs_q  <= 1'b1;
      s1_vs_q  <= 1'b1;
      s1_fs_q  <= 1'b0;
      s1_win_q <= 1'b0;
      de_q     <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      fs_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      s1_de_q  <= visible_c;
      s1_hs_q  <= hsync_raw_c;
      s1_vs_q  <= vsync_raw_c;
      s1_fs_q  <= first_c;
      s1_win_q <= in_win_c;
      de_q     <= s1_de_q;
      hs_q     <= s1_hs_q;
      vs_q     <= s1_vs_q;
      fs_q     <= s1_fs_q;
      rgb_q    <= s1_de_q ? colour_c : '0;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule
